dmi_jtag_host: RTL and testbench

DMI_JTAG_HOST -- requirements
Module: dmi_jtag_host

---
 rtl/dm.sv | 22 ++
 rtl/jtag_tck_gen.sv | 43 ++++
 rtl/dmi_jtag_host.sv | 145 ++++++++++++++
 tb/tb_dmi_jtag_host.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm.sv
// Debug-module constants and types shared by the JTAG DMI host.
package dm;

  localparam int unsigned DmiDrWidth = 41;
  localparam logic [4:0]  DmiIrValue = 5'h11;

  typedef enum logic [1:0] {
    DtmNop   = 2'h0,
    DtmRead  = 2'h1,
    DtmWrite = 2'h2,
    DtmRsvd  = 2'h3
  } dtm_op_e;

  typedef enum logic [2:0] {
    TapRst,
    IrScan,
    Idle,
    DrScan,
    Resp
  } host_state_e;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: ClkDiv cycles low then ClkDiv cycles high per period while enabled.
module jtag_tck_gen #(
  parameter int unsigned ClkDiv = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [8:0] RiseCnt = 9'(ClkDiv - 1);
  localparam logic [8:0] EndCnt  = 9'(2 * ClkDiv - 1);

  logic [8:0] cnt_d, cnt_q;
  logic       tck_d, tck_q;

  // fall_o marks the end of a period: the edge that drives TCK low again.
  assign rise_o = en_i && (cnt_q == RiseCnt);
  assign fall_o = en_i && (cnt_q == EndCnt);
  assign tck_o  = tck_q;

  always_comb begin
    cnt_d = '0;
    tck_d = 1'b0;
    if (en_i) begin
      cnt_d = fall_o ? 9'd0 : cnt_q + 9'd1;
      tck_d = rise_o ? 1'b1 : (fall_o ? 1'b0 : tck_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

endmodule

// File: rtl/dmi_jtag_host.sv
// JTAG host that resets the TAP, selects the DMI register and runs one DMI scan per request.
module dmi_jtag_host import dm::*; #(
  parameter int unsigned         ClkDiv   = 2,
  parameter int unsigned         IrLength = 5,
  parameter logic [IrLength-1:0] DmiIr    = IrLength'(DmiIrValue)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [6:0]  req_addr_i,
  input  logic [31:0] req_data_i,
  input  dtm_op_e     req_op_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic [1:0]  resp_status_o,
  output logic        tck_o,
  output logic        tms_o,
  output logic        tdi_o,
  input  logic        tdo_i
);

  localparam int unsigned DrW = DmiDrWidth;

  localparam logic [7:0] TapRstLast   = 8'd5;
  localparam logic [7:0] IrShiftFirst = 8'd4;
  localparam logic [7:0] IrShiftLast  = 8'(IrLength + 3);
  localparam logic [7:0] IrUpdate     = 8'(IrLength + 4);
  localparam logic [7:0] IrLast       = 8'(IrLength + 5);
  localparam logic [7:0] DrShiftFirst = 8'd3;
  localparam logic [7:0] DrShiftLast  = 8'(DmiDrWidth + 2);
  localparam logic [7:0] DrUpdate     = 8'(DmiDrWidth + 3);
  localparam logic [7:0] DrLast       = 8'(DmiDrWidth + 5);

  host_state_e    state_d, state_q;
  logic [7:0]     step_d, step_q;
  logic [DrW-1:0] shift_d, shift_q;
  logic           tdo_d, tdo_q;

  logic tck_en, tck_rise, tck_fall;
  logic ir_shift, dr_shift;

  assign tck_en   = state_q inside {TapRst, IrScan, DrScan};
  assign ir_shift = (state_q == IrScan) && (step_q >= IrShiftFirst) && (step_q <= IrShiftLast);
  assign dr_shift = (state_q == DrScan) && (step_q >= DrShiftFirst) && (step_q <= DrShiftLast);

  jtag_tck_gen #(
    .ClkDiv (ClkDiv)
  ) u_tck_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (tck_en),
    .tck_o  (tck_o),
    .rise_o (tck_rise),
    .fall_o (tck_fall)
  );

  // TDO is captured on the rising TCK edge but only shifted in at period end, so TDI
  // (the register LSB) never moves while TCK is high.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    shift_d = shift_q;
    tdo_d   = tck_rise ? tdo_i : tdo_q;

    unique case (state_q)
      TapRst: begin
        if (tck_fall) begin
          if (step_q == TapRstLast) begin
            state_d = IrScan;
            step_d  = '0;
            shift_d = DrW'(DmiIr);
          end else begin
            step_d = step_q + 8'd1;
          end
        end
      end
      IrScan: begin
        if (tck_fall) begin
          if (ir_shift) shift_d = {tdo_q, shift_q[DrW-1:1]};
          if (step_q == IrLast) begin
            state_d = Idle;
            step_d  = '0;
          end else begin
            step_d = step_q + 8'd1;
          end
        end
      end
      Idle: begin
        if (req_valid_i) begin
          state_d = DrScan;
          step_d  = '0;
          shift_d = {req_addr_i, req_data_i, req_op_i};
        end
      end
      DrScan: begin
        if (tck_fall) begin
          if (dr_shift) shift_d = {tdo_q, shift_q[DrW-1:1]};
          if (step_q == DrLast) begin
            state_d = Resp;
            step_d  = '0;
          end else begin
            step_d = step_q + 8'd1;
          end
        end
      end
      Resp: begin
        if (resp_ready_i) state_d = Idle;
      end
      default: state_d = TapRst;
    endcase
  end

  always_comb begin
    tms_o = 1'b0;
    unique case (state_q)
      TapRst:  tms_o = (step_q != TapRstLast);
      IrScan:  tms_o = (step_q <= 8'd1) || (step_q == IrShiftLast) || (step_q == IrUpdate);
      DrScan:  tms_o = (step_q == 8'd0) || (step_q == DrShiftLast) || (step_q == DrUpdate);
      default: tms_o = 1'b0;
    endcase
  end

  assign tdi_o         = (ir_shift || dr_shift) ? shift_q[0] : 1'b0;
  assign req_ready_o   = (state_q == Idle);
  assign resp_valid_o  = (state_q == Resp);
  assign resp_data_o   = resp_valid_o ? shift_q[33:2] : 32'h0;
  assign resp_status_o = resp_valid_o ? shift_q[1:0] : 2'h0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= TapRst;
      step_q  <= '0;
      shift_q <= '0;
      tdo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      shift_q <= shift_d;
      tdo_q   <= tdo_d;
    end
  end

endmodule

// File: tb/tb_dmi_jtag_host.sv
// Bench for dmi_jtag_host: behavioural TAP/DMI target plus request/response scoreboard.
module tb_dmi_jtag_host;
  import dm::*;

  localparam int unsigned Div     = 1;
  localparam int unsigned IrLen   = 5;
  localparam int unsigned InitTck = 6 + IrLen + 6;
  localparam int unsigned DrTck   = 47;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [6:0]  req_addr_i = '0;
  logic [31:0] req_data_i = '0;
  dtm_op_e     req_op_i = DtmNop;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_data_o;
  logic [1:0]  resp_status_o;
  logic        tck_o, tms_o, tdi_o;
  logic        tdo_i = 1'b0;

  dmi_jtag_host #(
    .ClkDiv   (Div),
    .IrLength (IrLen),
    .DmiIr    (5'h11)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_addr_i    (req_addr_i),
    .req_data_i    (req_data_i),
    .req_op_i      (req_op_i),
    .resp_valid_o  (resp_valid_o),
    .resp_ready_i  (resp_ready_i),
    .resp_data_o   (resp_data_o),
    .resp_status_o (resp_status_o),
    .tck_o         (tck_o),
    .tms_o         (tms_o),
    .tdi_o         (tdi_o),
    .tdo_i         (tdo_i)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboards: words the TAP should see, and responses the host should return.
  logic [40:0] sent_q[$];
  logic [33:0] resp_q[$];

  // ---------------- behavioural TAP with a DMI target ----------------
  typedef enum logic [3:0] {
    TTlr, TIdle, TSelDr, TCapDr, TShDr, TEx1Dr, TPauseDr, TEx2Dr, TUpdDr,
    TSelIr, TCapIr, TShIr, TEx1Ir, TPauseIr, TEx2Ir, TUpdIr
  } tap_e;

  function automatic tap_e tap_next(input tap_e s, input logic tms);
    case (s)
      TTlr:     return tms ? TTlr   : TIdle;
      TIdle:    return tms ? TSelDr : TIdle;
      TSelDr:   return tms ? TSelIr : TCapDr;
      TCapDr:   return tms ? TEx1Dr : TShDr;
      TShDr:    return tms ? TEx1Dr : TShDr;
      TEx1Dr:   return tms ? TUpdDr : TPauseDr;
      TPauseDr: return tms ? TEx2Dr : TPauseDr;
      TEx2Dr:   return tms ? TUpdDr : TShDr;
      TUpdDr:   return tms ? TSelDr : TIdle;
      TSelIr:   return tms ? TTlr   : TCapIr;
      TCapIr:   return tms ? TEx1Ir : TShIr;
      TShIr:    return tms ? TEx1Ir : TShIr;
      TEx1Ir:   return tms ? TUpdIr : TPauseIr;
      TPauseIr: return tms ? TEx2Ir : TPauseIr;
      TEx2Ir:   return tms ? TUpdIr : TShIr;
      default:  return tms ? TSelDr : TIdle;
    endcase
  endfunction

  tap_e        tap_st = TTlr;
  logic [4:0]  tap_ir = 5'h01;
  logic [4:0]  ir_sh = '0;
  logic [40:0] dr_sh = '0;
  int unsigned shcnt = 0;
  logic [31:0] tgt_mem[128];
  logic [6:0]  tgt_addr = '0;
  logic [31:0] tgt_data = '0;
  bit          force_busy = 1'b0;
  bit          tms_trace[$];
  bit          tdi_trace[$];

  task automatic tap_update(input logic [40:0] w);
    logic [40:0] exp_w;
    exp_w = 'x;
    if (sent_q.size() != 0) exp_w = sent_q.pop_front();
    check_val("dr_tdi_stream", w, exp_w);
    if (w[1:0] == 2'd1) begin
      tgt_data = tgt_mem[w[40:34]];
    end else if (w[1:0] == 2'd2) begin
      tgt_mem[w[40:34]] = w[33:2];
      tgt_data = w[33:2];
    end
    tgt_addr = w[40:34];
  endtask

  always @(posedge tck_o) begin
    tms_trace.push_back(tms_o);
    tdi_trace.push_back(tdi_o);
    case (tap_st)
      TTlr:   tap_ir = 5'h01;
      TCapDr: begin
        dr_sh = (tap_ir == DmiIrValue) ? {tgt_addr, tgt_data, force_busy ? 2'd3 : 2'd0} : '0;
        shcnt = 0;
      end
      TShDr:  begin
        dr_sh = {tdi_o, dr_sh[40:1]};
        shcnt++;
      end
      TUpdDr: if (tap_ir == DmiIrValue && shcnt == 41) tap_update(dr_sh);
      TCapIr: ir_sh = 5'h01;
      TShIr:  ir_sh = {tdi_o, ir_sh[4:1]};
      TUpdIr: tap_ir = ir_sh;
      default: ;
    endcase
    tap_st = tap_next(tap_st, tms_o);
  end

  always @(negedge tck_o) begin
    tdo_i = (tap_st == TShDr) ? dr_sh[0] : ((tap_st == TShIr) ? ir_sh[0] : 1'b0);
  end

  // ---------------- reference model of DMI results ----------------
  logic [31:0] ref_mem[128];
  logic [31:0] ref_data = '0;

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_outs"},
              {tck_o, tms_o, tdi_o, req_ready_o, resp_valid_o, resp_status_o, resp_data_o},
              {5'b01000, 2'b00, 32'h0});
  endtask

  // Called at the negedge where rst_i was just released.
  task automatic check_init(input string tag);
    int unsigned n = 0;
    int unsigned vbad = 0;
    logic [16:0] tms_v;
    logic [4:0]  tdi_v;
    tms_trace.delete();
    tdi_trace.delete();
    while (!req_ready_o && n < 500) begin
      @(negedge clk_i);
      n++;
      if (resp_valid_o) vbad++;
    end
    check_val({tag, "_ready_cycle"}, n, InitTck * 2 * Div);
    check_val({tag, "_tck_count"}, tms_trace.size(), InitTck);
    tms_v = 'x;
    tdi_v = 'x;
    if (tms_trace.size() >= InitTck) begin
      for (int i = 0; i < 17; i++) tms_v[16-i] = tms_trace[i];
      for (int i = 0; i < 5; i++) tdi_v[4-i] = tdi_trace[10+i];
    end
    check_val({tag, "_tms_trace"}, tms_v, 17'b11111_0_11_000000_11_0);
    check_val({tag, "_ir_tdi"}, tdi_v, 5'b10001);
    check_val({tag, "_tap_ir"}, tap_ir, 5'h11);
    check_val({tag, "_no_resp"}, vbad, 0);
  endtask

  task automatic do_txn(input logic [6:0] addr, input logic [31:0] data, input logic [1:0] op,
                        input bit busy, input int unsigned hold);
    int unsigned n;
    int unsigned acc;
    int unsigned held;
    logic [33:0] e;
    force_busy = busy;
    n = 0;
    while (!req_ready_o && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    check_val("req_ready_wait", req_ready_o, 1'b1);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_data_i  = data;
    req_op_i    = dtm_op_e'(op);
    sent_q.push_back({addr, data, op});
    resp_q.push_back({ref_data, busy ? 2'd3 : 2'd0});
    if (op == 2'd1) begin
      ref_data = ref_mem[addr];
    end else if (op == 2'd2) begin
      ref_mem[addr] = data;
      ref_data = data;
    end
    @(negedge clk_i);
    acc = cyc;
    req_valid_i  = 1'b0;
    req_addr_i   = ~addr;
    req_data_i   = ~data;
    resp_ready_i = (hold == 0);
    n = 0;
    while (!resp_valid_o && n < 4000) begin
      @(negedge clk_i);
      n++;
      if (n == 10) req_valid_i = 1'b1;
    end
    check_val("resp_valid_seen", resp_valid_o, 1'b1);
    check_val("resp_latency", cyc - acc, DrTck * 2 * Div);
    check_val("ready_low_in_resp", req_ready_o, 1'b0);
    e = 'x;
    if (resp_q.size() != 0) e = resp_q.pop_front();
    check_val("resp_data", resp_data_o, e[33:2]);
    check_val("resp_status", resp_status_o, e[1:0]);
    if (hold != 0) begin
      held = 0;
      for (int i = 0; i < int'(hold); i++) begin
        @(negedge clk_i);
        if (resp_valid_o && !req_ready_o && resp_data_o === e[33:2] && resp_status_o === e[1:0])
          held++;
      end
      check_val("resp_hold", held, hold);
      resp_ready_i = 1'b1;
    end
    req_valid_i = 1'b0;
    @(negedge clk_i);
    check_val("resp_done", {resp_valid_o, req_ready_o}, 2'b01);
    resp_ready_i = 1'b0;
    force_busy = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = '0;
      tgt_mem[i] = '0;
    end
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check_reset_vals("reset");
    rst_i = 1'b0;
    check_init("init");

    do_txn(7'h11, 32'h0000_0000, 2'd1, 1'b0, 0);
    do_txn(7'h04, 32'hDEAD_BEEF, 2'd2, 1'b0, 0);
    do_txn(7'h04, 32'h0000_0000, 2'd1, 1'b0, 0);
    do_txn(7'h10, 32'h0F0F_0F0F, 2'd0, 1'b1, 0);
    do_txn(7'h22, 32'h1234_5678, 2'd2, 1'b0, 50);
    do_txn(7'h05, 32'hA5A5_A5A5, 2'd3, 1'b0, 0);
    do_txn(7'h22, 32'h0000_0000, 2'd1, 1'b0, 3);

    // Abort a scan mid-shift: nothing must reach the target and no response appears.
    while (!req_ready_o) @(negedge clk_i);
    req_valid_i = 1'b1;
    req_addr_i  = 7'h04;
    req_data_i  = 32'h0;
    req_op_i    = DtmRead;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (41) @(negedge clk_i);
    check_val("abort_pre_resp", resp_valid_o, 1'b0);
    rst_i = 1'b1;
    #1;
    check_reset_vals("abort");
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    check_init("replay");
    do_txn(7'h04, 32'h0000_0000, 2'd1, 1'b0, 0);

    check_val("sent_q_drained", sent_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
